// File: rtl/mux_n_pipe_pkg.sv
// Shared constants for the N-way pipelined mux: mode encodings and beat counter width.
package mux_n_pipe_pkg;
  localparam logic MODO_FIJO = 1'b0;
  localparam logic MODO_RR   = 1'b1;
  localparam int   CNT_W     = 16;

  // Saturating increment for the accepted-beat counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/mux_n_pipe_rr_arbiter.sv
// Round-robin grant: first requester found scanning ptr, ptr+1, ... modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  localparam logic [SEL_W:0] NL = (SEL_W+1)'(N);

  logic [SEL_W:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single subtract wraps the scan position
      j = {1'b0, ptr} + (SEL_W+1)'(k);
      if (j >= NL) j = j - NL;
      if (!any && req[j[SEL_W-1:0]]) begin
        any = 1'b1;
        idx = j[SEL_W-1:0];
      end
    end
    grant[idx] = any;
  end
endmodule

// File: rtl/mux_n_pipe.sv
// N-input mux with fixed-select or round-robin arbitration into a single registered output beat.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] datos,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  modo,
  output logic [WIDTH-1:0]      salida,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      src,
  output logic                  err_sel,
  output logic [CNT_W-1:0]      cnt
);
  localparam logic [SEL_W:0]     N_L  = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0]   LAST = SEL_W'(N_IN-1);

  logic [N_IN-1:0][WIDTH-1:0] ch;
  logic [SEL_W-1:0]           ptr, rr_idx, g_idx;
  logic [N_IN-1:0]            rr_grant, rdy;
  logic                       rr_any, sel_ok, free, xfer;

  assign ch = datos;

  rr_arbiter #(.N(N_IN), .SEL_W(SEL_W)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign sel_ok = ({1'b0, sel} < N_L);
  assign free   = !out_valid || out_ready;

  // Fixed mode offers ready on sel even without a pending valid.
  always_comb begin
    rdy = '0;
    if (rst_n && free) begin
      if (modo == MODO_RR) rdy = rr_grant;
      else if (sel_ok)     rdy[sel] = 1'b1;
    end
  end

  assign in_ready = rdy;
  assign xfer     = |(rdy & in_valid);
  assign g_idx    = (modo == MODO_RR) ? rr_idx : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      salida    <= '0;
      src       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      salida    <= ch[g_idx];
      src       <= g_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ptr <= '0;
    else if (modo == MODO_RR && xfer)    ptr <= (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (out_valid && out_ready) cnt <= sat_inc(cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_sel <= 1'b0;
    else if (modo == MODO_FIJO && !sel_ok) err_sel <= 1'b1;
  end

  logic unused_any;
  assign unused_any = rr_any;
endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: scoreboard of expected beats plus a reference arbiter model.
module tb_mux_n_pipe;
  import mux_n_pipe_pkg::*;
  localparam int W = 32, N = 4, SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][W-1:0] ch;
  logic [N-1:0]        in_valid, in_ready;
  logic [SW-1:0]       sel, src;
  logic                modo, out_valid, out_ready, err_sel;
  logic [W-1:0]        salida;
  logic [15:0]         cnt;

  logic [2:0][W-1:0]   ch3;
  logic [2:0]          iv3, rdy3;
  logic [1:0]          sel3, src3;
  logic                modo3, ov3, or3, err3;
  logic [W-1:0]        sal3;
  logic [15:0]         cnt3;

  mux_n_pipe #(.WIDTH(W), .N_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .datos(ch), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .modo(modo), .salida(salida), .out_valid(out_valid), .out_ready(out_ready),
    .src(src), .err_sel(err_sel), .cnt(cnt)
  );

  mux_n_pipe #(.WIDTH(W), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .datos(ch3), .in_valid(iv3), .in_ready(rdy3),
    .sel(sel3), .modo(modo3), .salida(sal3), .out_valid(ov3), .out_ready(or3),
    .src(src3), .err_sel(err3), .cnt(cnt3)
  );

  typedef struct packed { logic [W-1:0] d; logic [SW-1:0] s; } beat_t;
  beat_t       mq[$];
  int          mptr, total, bad;
  logic [15:0] mcnt;
  logic [W-1:0] mlast;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    r = '0;
    if (!rst_n || !(mq.size() == 0 || out_ready)) return r;
    if (modo == MODO_FIJO) r[sel] = 1'b1;
    else
      for (int k = 0; k < N; k++)
        if (in_valid[(mptr + k) % N]) begin
          r[(mptr + k) % N] = 1'b1;
          break;
        end
    return r;
  endfunction

  // One cycle: compare at negedge against the model, then advance past posedge.
  task automatic tick();
    logic [N-1:0] er;
    @(negedge clk);
    check("cnt", cnt, mcnt);
    check("err_sel", err_sel, 0);
    check("out_valid", out_valid, mq.size() != 0);
    er = exp_rdy();
    check("in_ready", in_ready, er);
    if (mq.size() != 0) begin
      check("salida", salida, mq[0].d);
      check("src", src, mq[0].s);
      if (out_ready) begin
        mlast = mq[0].d;
        void'(mq.pop_front());
        if (mcnt != 16'hFFFF) mcnt++;
      end
    end else begin
      check("salida_hold", salida, mlast);
    end
    for (int i = 0; i < N; i++)
      if (er[i] && in_valid[i]) begin
        mq.push_back(beat_t'{d: ch[i], s: SW'(i)});
        if (modo == MODO_RR) mptr = (i + 1) % N;
      end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0; mcnt = '0; mptr = 0; mlast = '0;
    ch = '0; sel = '0; modo = MODO_FIJO;
    ch3 = '0; iv3 = '0; sel3 = '0; modo3 = MODO_FIJO; or3 = 1'b1;
    // requests pending during reset must see no ready
    in_valid = '1; out_ready = 1'b1;
    tick(); tick();
    check("rst_salida", salida, 0);
    check("rst_src", src, 0);
    check("rst_err3", err3, 0);
    rst_n = 1'b1; in_valid = '0;
    tick();

    // fixed select of channel 2
    ch[2] = 32'hCAFE0002; sel = 2'd2; in_valid = 4'b0100;
    tick();
    check("r36_ov", out_valid, 1);
    check("r36_salida", salida, 32'hCAFE0002);
    check("r36_src", src, 2);
    in_valid = '0;
    tick();
    check("r36_cnt", cnt, 1);

    // selected channel idle while others request: ready offered, nothing moves
    sel = 2'd1; in_valid = 4'b1100;
    tick(); tick();

    // round-robin, all requesting
    modo = MODO_RR; in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) ch[i] = $urandom;
      tick();
      check("r37_src", src, k % 4);
    end
    in_valid = '0;
    tick();
    check("r37_cnt", cnt, 9);

    // random mix of modes, selects, requests and backpressure
    for (int k = 0; k < 32; k++) begin
      modo = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) ch[i] = $urandom;
      tick();
    end

    // stall for three cycles, then back-to-back beats
    modo = MODO_FIJO; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    ch[1] = 32'hA0A0_0001;
    tick();
    out_ready = 1'b0; ch[1] = 32'hB0B0_0002;
    tick(); tick(); tick();
    check("r39_hold_salida", salida, 32'hA0A0_0001);
    check("r39_hold_src", src, 1);
    check("r39_hold_ov", out_valid, 1);
    out_ready = 1'b1; ch[1] = 32'hC0C0_0003;
    tick();
    check("r39_b2b_c", salida, 32'hC0C0_0003);
    ch[1] = 32'hD0D0_0004;
    tick();
    check("r39_b2b_d", salida, 32'hD0D0_0004);
    check("r39_b2b_ov", out_valid, 1);
    in_valid = '0;
    tick(); tick();

    // three-channel instance: out-of-range select
    ch3[0] = 32'h3333_0000; ch3[1] = 32'h3333_0001; ch3[2] = 32'h3333_0002;
    sel3 = 2'd3; iv3 = 3'b111;
    @(negedge clk);
    check("r38_rdy", rdy3, 0);
    check("r38_ov", ov3, 0);
    check("r38_err_pre", err3, 0);
    @(posedge clk); #1;
    check("r38_err", err3, 1);
    check("r38_ov_post", ov3, 0);
    sel3 = 2'd0;
    @(posedge clk); #1;
    check("r38_err_sticky", err3, 1);
    check("r38_ov_ok", ov3, 1);
    check("r38_sal_ok", sal3, 32'h3333_0000);
    iv3 = '0;

    // reset mid-stream
    modo = MODO_RR; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) ch[i] = 32'h5000_0000 + i;
    tick(); tick(); tick();
    check("r40_ov_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r40_ov", out_valid, 0);
    check("r40_cnt", cnt, 0);
    check("r40_salida", salida, 0);
    check("r40_src", src, 0);
    check("r40_rdy", in_ready, 0);
    check("r40_err3", err3, 0);
    mq.delete(); mcnt = '0; mptr = 0; mlast = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("r40_first_src", src, 0);
    check("r40_first_ov", out_valid, 1);
    tick(); tick();

    // counter saturation
    repeat (65540) @(posedge clk);
    #1;
    check("cnt_sat", cnt, 16'hFFFF);
    @(posedge clk); #1;
    check("cnt_sat_hold", cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter WIDTH, 32, data width of every channel and of salida.
REQ-002 Parameter N_IN, 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, $clog2(N_IN), width of sel and src.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 datos  input  N_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_IN  per-channel valid.
REQ-008 in_ready  output  N_IN  per-channel ready; one-hot or zero.
REQ-009 sel  input  SEL_W  channel select, used when modo=0.
REQ-010 modo  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-011 salida  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  salida holds a beat.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 src  output  SEL_W  channel index that produced salida.
REQ-015 err_sel  output  1  sticky flag: out-of-range sel seen with modo=0.
REQ-016 cnt  output  16  number of accepted output beats, saturating.

Function
REQ-017 Output register is "free" when out_valid=0 or out_ready=1 (same cycle).
REQ-018 Fixed mode: grant = sel when sel < N_IN and in_valid[sel]=1 and register free; in_ready[sel] = register free, independent of in_valid.
REQ-019 Fixed mode, sel >= N_IN: no grant, in_ready all 0, err_sel set on the next edge; no beat is generated, default zero data never emitted.
REQ-020 Round-robin: grant = first channel with in_valid=1 scanning ptr, ptr+1, ... wrapping modulo N_IN; in_ready asserted only on the granted channel, only when register free.
REQ-021 Round-robin pointer ptr updates to (grant+1) mod N_IN on every granted transfer; unchanged otherwise; unchanged while modo=0.
REQ-022 Transfer on channel i when in_valid[i] and in_ready[i]: next edge loads salida=channel i data, src=i, out_valid=1.
REQ-023 Latency: input handshake to out_valid = 1 cycle; throughput 1 beat/cycle when out_ready held high.
REQ-024 Simultaneous out_ready=1 and new grant: old beat retires and new beat loads on the same edge, no bubble.
REQ-025 out_valid=1 and out_ready=0: salida, src stable; no in_ready asserted.
REQ-026 No grant and out_ready=1: out_valid clears next edge; salida retains last value.
REQ-027 cnt increments on each out_valid and out_ready cycle; holds at 16'hFFFF.
REQ-028 modo or sel change takes effect combinationally for the current cycle's grant; an in-flight output beat is unaffected.
REQ-029 err_sel clears only on reset.

Reset
REQ-030 rst_n=0 asynchronously forces out_valid=0, salida=0, src=0, ptr=0, err_sel=0, cnt=0.
REQ-031 in_ready is 0 whenever rst_n=0; a beat held at reset is discarded.
REQ-032 Deassertion is synchronised by the system; block makes no grant in the first edge after rst_n rises only if register not free (normal rules apply).

Structure
REQ-033 Mode encodings (MODO_FIJO=0, MODO_RR=1) and the cnt width constant live in the shared package.
REQ-034 Round-robin grant logic is one sub-module, rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index, any).
REQ-035 Output register, counter and error flag stay in mux_n_pipe.

Verification
REQ-036 modo=0, sel=2, in_valid=4'b0100, ch2=32'hCAFE0002, out_ready=1 -> next cycle salida=32'hCAFE0002, src=2, out_valid=1, cnt=1.
REQ-037 modo=1, in_valid=4'b1111 held 8 cycles, out_ready=1 -> src sequence 0,1,2,3,0,1,2,3, cnt=8.
REQ-038 N_IN=3, modo=0, sel=3, all valid -> in_ready=0, out_valid stays 0, err_sel=1 from next cycle until reset.
REQ-039 out_ready=0 for 3 cycles with out_valid=1 -> salida/src constant, in_ready=0; out_ready=1 with new valid -> back-to-back beat, no bubble.
REQ-040 rst_n pulsed low mid-stream with out_valid=1, cnt=5 -> immediately out_valid=0, cnt=0, ptr=0; first round-robin grant after release is channel 0.
